// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
// Purpose: FSM state encoding, the hard-wired zero register address and
//          the width of the flush countdown.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  localparam logic [4:0] ZERO_REG    = 5'd0;
  localparam int         FLUSH_CNT_W = 3;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating event counter
// Purpose: counts cycles where inc_i is high, sticking at all-ones.
// Ports:
//   clk_i  in   clock, rising edge
//   rst_i  in   asynchronous reset, active-high (clears count)
//   inc_i  in   increment request for this cycle
//   cnt_o  out  current count (CNT_W bits)
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID/EX pipeline hazard controller
// Purpose: detects load-use hazards, flushes on taken branches and freezes
//          the pipeline while data memory is busy; counts stall/flush events.
// Ports:
//   clk_i, rst_i                 clock / async active-high reset
//   id_rs1_i, id_rs2_i           source registers of the ID instruction
//   id_uses_rs2_i                ID instruction actually reads rs2
//   ex_memread_i, ex_regwrite_i  control of the EX instruction
//   ex_rd_i                      destination register of the EX instruction
//   ex_branch_i                  EX instruction is a taken branch
//   mem_busy_i                   data memory stall, freeze everything
//   pc_write_o, if_id_write_o    register write enables
//   if_id_flush_o                IF_ID loads a NOP
//   id_ex_bubble_o               zero control into ID_EX
//   stall_cnt_o, flush_cnt_o     saturating event counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_memread_i,
  input  logic             ex_regwrite_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_branch_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // The branch cycle itself is the first bubble, so the countdown covers the rest.
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_t                 state, next_state;
  logic [FLUSH_CNT_W-1:0] cnt, next_cnt;
  logic                   load_use;
  logic                   flush_mode;
  logic                   stall_inc, flush_inc;

  assign load_use = ex_memread_i && ex_regwrite_i && (ex_rd_i != ZERO_REG) &&
                    ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state     = state;
    next_cnt       = cnt;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    // Outputs are zero-latency, so the cycle that leaves FREEZE already
    // behaves like the state it is heading to (FLUSH with countdown left, else RUN).
    flush_mode     = (state == ST_FLUSH) || ((state == ST_FREEZE) && (cnt != '0));

    if (mem_busy_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      next_state    = ST_FREEZE;
    end else if (flush_mode) begin
      // A branch seen here is the bubble we inserted, so it is ignored.
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
      if (cnt <= FLUSH_CNT_W'(1)) begin
        next_state = ST_RUN;
        next_cnt   = '0;
      end else begin
        next_state = ST_FLUSH;
        next_cnt   = cnt - 1'b1;
      end
    end else if (ex_branch_i) begin
      // Branch outranks load-use: the stalled ID instruction is discarded anyway.
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
      flush_inc      = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        next_state = ST_FLUSH;
        next_cnt   = FLUSH_INIT;
      end else begin
        next_state = ST_RUN;
      end
    end else if (load_use) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
      stall_inc      = 1'b1;
      next_state     = ST_RUN;
    end else begin
      next_state = ST_RUN;
    end

    if (rst_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs2 = 1'b0, ex_memread = 1'b0, ex_regwrite = 1'b0;
  logic       ex_branch = 1'b0, mem_busy = 1'b0;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [3:0] stall_cnt, flush_cnt;

  typedef struct {
    string      name;
    logic [3:0] ctl;   // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_uses_rs2_i  (id_uses_rs2),
    .ex_memread_i   (ex_memread),
    .ex_regwrite_i  (ex_regwrite),
    .ex_rd_i        (ex_rd),
    .ex_branch_i    (ex_branch),
    .mem_busy_i     (mem_busy),
    .pc_write_o     (pc_write),
    .if_id_write_o  (if_id_write),
    .if_id_flush_o  (if_id_flush),
    .id_ex_bubble_o (id_ex_bubble),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  // Monitor: one observation per cycle, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        logic [3:0] act;
        e   = q.pop_front();
        act = {pc_write, if_id_write, if_id_flush, id_ex_bubble};
        total++;
        if (act !== e.ctl || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
          bad++;
          $display("FAIL %s: got ctl=%b sc=%0d fc=%0d, want ctl=%b sc=%0d fc=%0d",
                   e.name, act, stall_cnt, flush_cnt, e.ctl, e.sc, e.fc);
        end
      end
    end
  end

  // Drive one cycle of inputs and record what that cycle must produce.
  task automatic v(input string name, input logic r,
                   input logic [4:0] rs1, input logic [4:0] rs2, input logic u,
                   input logic mr, input logic rw, input logic [4:0] rd,
                   input logic br, input logic busy,
                   input logic [3:0] ctl, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u;
    ex_memread = mr; ex_regwrite = rw; ex_rd = rd;
    ex_branch = br; mem_busy = busy;
    e.name = name; e.ctl = ctl; e.sc = 4'(sc); e.fc = 4'(fc);
    q.push_back(e);
  endtask

  localparam logic [3:0] NORM  = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLSH  = 4'b1111;
  localparam logic [3:0] FRZ   = 4'b0000;
  localparam logic [3:0] RSTO  = 4'b0011;

  initial begin
    int wait_cyc;
    //  name          rst rs1 rs2 u  mr rw rd br busy  ctl    sc fc
    v("reset",        1, 0,  0,  0, 0, 0, 0, 0, 0,    RSTO,  0, 0);
    v("idle",         0, 1,  0,  0, 0, 0, 0, 0, 0,    NORM,  0, 0);
    v("lu_rs1",       0, 5,  0,  0, 1, 1, 5, 0, 0,    STALL, 0, 0);
    v("lu_after",     0, 1,  0,  0, 0, 0, 0, 0, 0,    NORM,  1, 0);
    v("lu_x0",        0, 0,  0,  0, 1, 1, 0, 0, 0,    NORM,  1, 0);
    v("rs2_unused",   0, 1,  7,  0, 1, 1, 7, 0, 0,    NORM,  1, 0);
    v("rs2_used",     0, 1,  7,  1, 1, 1, 7, 0, 0,    STALL, 1, 0);
    v("rs2_after",    0, 1,  0,  0, 0, 0, 0, 0, 0,    NORM,  2, 0);
    v("no_regwrite",  0, 5,  0,  0, 1, 0, 5, 0, 0,    NORM,  2, 0);
    v("br_take",      0, 1,  0,  0, 0, 0, 0, 1, 0,    FLSH,  2, 0);
    v("br_flush2",    0, 1,  0,  0, 0, 0, 0, 1, 0,    FLSH,  2, 1);
    v("br_flush3",    0, 1,  0,  0, 0, 0, 0, 0, 0,    FLSH,  2, 1);
    v("br_done",      0, 1,  0,  0, 0, 0, 0, 0, 0,    NORM,  2, 1);
    v("br_lu",        0, 5,  0,  0, 1, 1, 5, 1, 0,    FLSH,  2, 1);
    v("br_lu_f2",     0, 1,  0,  0, 0, 0, 0, 0, 0,    FLSH,  2, 2);
    v("br_lu_f3",     0, 1,  0,  0, 0, 0, 0, 0, 0,    FLSH,  2, 2);
    v("br_lu_done",   0, 1,  0,  0, 0, 0, 0, 0, 0,    NORM,  2, 2);
    v("frz_br",       0, 1,  0,  0, 0, 0, 0, 1, 0,    FLSH,  2, 2);
    v("frz_1",        0, 1,  0,  0, 0, 0, 0, 0, 1,    FRZ,   2, 3);
    v("frz_2",        0, 1,  0,  0, 0, 0, 0, 0, 1,    FRZ,   2, 3);
    v("frz_3_br",     0, 1,  0,  0, 0, 0, 0, 1, 1,    FRZ,   2, 3);
    v("frz_4_lu",     0, 5,  0,  0, 1, 1, 5, 0, 1,    FRZ,   2, 3);
    v("frz_exit_b1",  0, 1,  0,  0, 0, 0, 0, 0, 0,    FLSH,  2, 3);
    v("frz_exit_b2",  0, 1,  0,  0, 0, 0, 0, 0, 0,    FLSH,  2, 3);
    v("frz_done",     0, 1,  0,  0, 0, 0, 0, 0, 0,    NORM,  2, 3);
    v("run_frz",      0, 1,  0,  0, 0, 0, 0, 0, 1,    FRZ,   2, 3);
    v("frz_exit_lu",  0, 5,  0,  0, 1, 1, 5, 0, 0,    STALL, 2, 3);
    v("frz_lu_after", 0, 1,  0,  0, 0, 0, 0, 0, 0,    NORM,  3, 3);
    for (int k = 0; k < 20; k++) begin
      v("sat_stall",  0, 9,  0,  0, 1, 1, 9, 0, 0,    STALL, (3 + k > 15) ? 15 : 3 + k, 3);
      v("sat_idle",   0, 1,  0,  0, 0, 0, 0, 0, 0,    NORM,  (4 + k > 15) ? 15 : 4 + k, 3);
    end
    v("rst_br",       0, 1,  0,  0, 0, 0, 0, 1, 0,    FLSH,  15, 3);
    v("rst_midflush", 1, 1,  0,  0, 0, 0, 0, 0, 0,    RSTO,  0, 0);
    v("rst_release",  0, 1,  0,  0, 0, 0, 0, 0, 0,    NORM,  0, 0);
    v("rst_lu",       0, 5,  0,  0, 1, 1, 5, 0, 0,    STALL, 0, 0);
    v("rst_lu_after", 0, 1,  0,  0, 0, 0, 0, 0, 0,    NORM,  1, 0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 100) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
